// File: rtl/doa_tracker.sv
// Direction-of-arrival tracker: resolves a bearing from four LUT-mapped sensor
// channels, averages N hits around a reference angle and flags a lost target.
module doa_tracker #(
   parameter int CODE_W   = 7,
   parameter int LUTA_W   = 7,
   parameter int ANG_W    = 9,
   parameter int LO       = 40,
   parameter int HI       = 90,
   parameter int AVG_LOG2 = 2,
   parameter int TIMEOUT  = 1024
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [CODE_W-1:0] code_x1,
   input  logic [CODE_W-1:0] code_x2,
   input  logic [CODE_W-1:0] code_y1,
   input  logic [CODE_W-1:0] code_y2,
   input  logic [LUTA_W-1:0] lut_x1,
   input  logic [LUTA_W-1:0] lut_x2,
   input  logic [LUTA_W-1:0] lut_y1,
   input  logic [LUTA_W-1:0] lut_y2,
   output logic [ANG_W-1:0]  theta,
   output logic              theta_valid,
   output logic              lost
);

   localparam int N      = 1 << AVG_LOG2;
   localparam int SUM_W  = $clog2(N * 180 + 1) + 1;
   localparam int MISS_W = $clog2(TIMEOUT + 1);
   localparam int SW     = ANG_W + 2;

   localparam logic [AVG_LOG2:0] CNT_FULL = N[AVG_LOG2:0];
   localparam logic [MISS_W-1:0] MISS_MAX = TIMEOUT[MISS_W-1:0];

   typedef logic signed [SW-1:0] sang_t;

   typedef struct packed {
      logic [CODE_W-1:0] cx1, cx2, cy1, cy2;
      logic [LUTA_W-1:0] lx1, lx2, ly1, ly2;
   } sample_t;

   typedef enum logic {IDLE, ACCUM} state_t;

   // ---------------- S1: input capture ----------------
   logic    s1_valid_q;
   sample_t s1_q;

   always_ff @(posedge clock) begin
      if (!reset_n) s1_valid_q <= 1'b0;
      else          s1_valid_q <= in_valid;
   end

   // NOTE: datapath registers carry no reset; they are only observed while the matching valid/state bit says so.
   always_ff @(posedge clock) begin
      if (in_valid) begin
         s1_q <= '{cx1: code_x1, cx2: code_x2, cy1: code_y1, cy2: code_y2,
                   lx1: lut_x1,  lx2: lut_x2,  ly1: lut_y1,  ly2: lut_y2};
      end
   end

   // ---------------- S2: raw angle resolution ----------------
   logic        rng_x1, rng_x2, rng_y1, rng_y2;
   logic        x1_pos, y2_pos;
   logic [3:0]  det;
   sang_t       ax1, ax2, ay1, ay2, raw;
   logic        s2_hit_d, s2_hit_q, s2_valid_q;
   logic [ANG_W-1:0] s2_raw_d, s2_raw_q;

   assign rng_x1 = (s1_q.lx1 >= LUTA_W'(LO)) && (s1_q.lx1 <= LUTA_W'(HI));
   assign rng_x2 = (s1_q.lx2 >= LUTA_W'(LO)) && (s1_q.lx2 <= LUTA_W'(HI));
   assign rng_y1 = (s1_q.ly1 >= LUTA_W'(LO)) && (s1_q.ly1 <= LUTA_W'(HI));
   assign rng_y2 = (s1_q.ly2 >= LUTA_W'(LO)) && (s1_q.ly2 <= LUTA_W'(HI));
   assign x1_pos = (s1_q.lx1 != '0);
   assign y2_pos = (s1_q.ly2 != '0);
   assign det    = {s1_q.cx1 != '1, s1_q.cx2 != '1, s1_q.cy1 != '1, s1_q.cy2 != '1};
   assign ax1    = sang_t'(s1_q.lx1);
   assign ax2    = sang_t'(s1_q.lx2);
   assign ay1    = sang_t'(s1_q.ly1);
   assign ay2    = sang_t'(s1_q.ly2);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      s2_hit_d = 1'b1;
      raw      = '0;
      if (rng_x1)              raw = y2_pos ? ax1 : sang_t'(360) - ax1;
      else if (rng_x2)         raw = y2_pos ? sang_t'(180) - ax2 : sang_t'(180) + ax2;
      else if (rng_y1)         raw = x1_pos ? sang_t'(270) + ay1 : sang_t'(270) - ay1;
      else if (rng_y2)         raw = x1_pos ? sang_t'(90) - ay2 : sang_t'(90) + ay2;
      else if (det == 4'b1000) raw = sang_t'(0);
      else if (det == 4'b0001) raw = sang_t'(90);
      else if (det == 4'b0100) raw = sang_t'(180);
      else if (det == 4'b0010) raw = sang_t'(270);
      else                     s2_hit_d = 1'b0;
      // Raw results span roughly -127..397; one correction step lands in 0..359.
      if (raw < sang_t'(0))          raw = raw + sang_t'(360);
      else if (raw >= sang_t'(360))  raw = raw - sang_t'(360);
      s2_raw_d = ANG_W'(raw);
   end

   always_ff @(posedge clock) begin
      if (!reset_n) s2_valid_q <= 1'b0;
      else          s2_valid_q <= s1_valid_q;
   end

   always_ff @(posedge clock) begin
      s2_hit_q <= s2_hit_d;
      s2_raw_q <= s2_raw_d;
   end

   // ---------------- S3: accumulator FSM, miss counter, outputs ----------------
   state_t                   state_q, state_d;
   logic [ANG_W-1:0]         ref_q, ref_d;
   logic signed [SUM_W-1:0]  sum_q, sum_d;
   logic [AVG_LOG2:0]        cnt_q, cnt_d;
   logic [MISS_W-1:0]        miss_q, miss_d;
   logic [ANG_W-1:0]         theta_q, theta_d;
   logic                     tv_q, tv_d;
   logic                     lost_q, lost_d;
   sang_t                    diff, tsum;

   always_comb begin
      state_d = state_q;
      ref_d   = ref_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      miss_d  = miss_q;
      theta_d = theta_q;
      tv_d    = 1'b0;
      lost_d  = lost_q;
      tsum    = '0;
      // Shortest signed distance from the reference, folded into [-180,179].
      diff = sang_t'(s2_raw_q) - sang_t'(ref_q);
      if (diff >= sang_t'(180))       diff = diff - sang_t'(360);
      else if (diff < sang_t'(-180))  diff = diff + sang_t'(360);

      if (s2_valid_q && s2_hit_q) begin
         miss_d = '0;
         if (state_q == IDLE) begin
            ref_d   = s2_raw_q;
            sum_d   = '0;
            cnt_d   = 1;
            state_d = ACCUM;
         end else begin
            sum_d = sum_q + SUM_W'(diff);
            cnt_d = cnt_q + 1'b1;
         end
         if (cnt_d == CNT_FULL) begin
            tsum = sang_t'(ref_d) + sang_t'(sum_d >>> AVG_LOG2);
            if (tsum < sang_t'(0))          tsum = tsum + sang_t'(360);
            else if (tsum >= sang_t'(360))  tsum = tsum - sang_t'(360);
            theta_d = ANG_W'(tsum);
            tv_d    = 1'b1;
            lost_d  = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
            sum_d   = '0;
         end
      end else if (s2_valid_q) begin
         if (miss_q != MISS_MAX) miss_d = miss_q + 1'b1;
         if (miss_d == MISS_MAX) begin
            lost_d  = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
            sum_d   = '0;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= IDLE;
         sum_q   <= '0;
         cnt_q   <= '0;
         miss_q  <= '0;
         theta_q <= '0;
         tv_q    <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         miss_q  <= miss_d;
         theta_q <= theta_d;
         tv_q    <= tv_d;
         lost_q  <= lost_d;
      end
   end

   always_ff @(posedge clock) begin
      ref_q <= ref_d;
   end

   assign theta       = theta_q;
   assign theta_valid = tv_q;
   assign lost        = lost_q;

endmodule

// File: tb/tb_doa_tracker.sv
// Scoreboard bench for doa_tracker: a high-level bearing model predicts each
// emission and the lost/theta outputs; a negedge monitor compares them.
module tb_doa_tracker;

   localparam int CODE_W   = 7;
   localparam int LUTA_W   = 7;
   localparam int ANG_W    = 9;
   localparam int LO       = 40;
   localparam int HI       = 90;
   localparam int AVG_LOG2 = 2;
   localparam int TIMEOUT  = 1024;
   localparam int N        = 1 << AVG_LOG2;
   localparam int NONE     = (1 << CODE_W) - 1;
   localparam int DEPTH    = 8192;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              in_valid = 1'b0;
   logic [CODE_W-1:0] code_x1 = '1, code_x2 = '1, code_y1 = '1, code_y2 = '1;
   logic [LUTA_W-1:0] lut_x1 = '0, lut_x2 = '0, lut_y1 = '0, lut_y2 = '0;
   logic [ANG_W-1:0]  theta;
   logic              theta_valid;
   logic              lost;

   doa_tracker #(
      .CODE_W(CODE_W), .LUTA_W(LUTA_W), .ANG_W(ANG_W), .LO(LO), .HI(HI),
      .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clock), .reset_n(reset_n), .in_valid(in_valid),
      .code_x1(code_x1), .code_x2(code_x2), .code_y1(code_y1), .code_y2(code_y2),
      .lut_x1(lut_x1), .lut_x2(lut_x2), .lut_y1(lut_y1), .lut_y2(lut_y2),
      .theta(theta), .theta_valid(theta_valid), .lost(lost)
   );

   always #5 clock = ~clock;

   typedef struct {int cx1, cx2, cy1, cy2, lx1, lx2, ly1, ly2;} smp_t;
   typedef struct {int theta; int at_edge;} emit_t;

   emit_t exp_q[$];
   bit    exp_lost[DEPTH];
   int    exp_theta[DEPTH];
   int    edge_cnt = 0;
   int    n_cmp = 0;
   int    n_bad = 0;
   bit    chk_en = 1'b0;

   // Reference model state: the hits of the open window, in arrival order.
   int win[$];
   int m_miss  = 0;
   bit m_lost  = 1'b0;
   int m_theta = 0;

   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, req);
      end
   endtask

   function automatic bit in_rng(input int a);
      return (a >= LO) && (a <= HI);
   endfunction

   function automatic int wrap360(input int a);
      return ((a % 360) + 360) % 360;
   endfunction

   function automatic int norm180(input int d);
      return wrap360(d + 180) - 180;
   endfunction

   function automatic int floor_div(input int s, input int d);
      int q;
      q = s / d;
      if ((s % d != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   function automatic void resolve(input smp_t s, output bit hit, output int r);
      int nd;
      hit = 1'b1;
      r   = 0;
      nd  = int'(s.cx1 != NONE) + int'(s.cx2 != NONE) + int'(s.cy1 != NONE) + int'(s.cy2 != NONE);
      if (in_rng(s.lx1))      r = (s.ly2 > 0) ? s.lx1 : 360 - s.lx1;
      else if (in_rng(s.lx2)) r = (s.ly2 > 0) ? 180 - s.lx2 : 180 + s.lx2;
      else if (in_rng(s.ly1)) r = (s.lx1 > 0) ? 270 + s.ly1 : 270 - s.ly1;
      else if (in_rng(s.ly2)) r = (s.lx1 > 0) ? 90 - s.ly2 : 90 + s.ly2;
      else if (nd == 1 && s.cx1 != NONE) r = 0;
      else if (nd == 1 && s.cy2 != NONE) r = 90;
      else if (nd == 1 && s.cx2 != NONE) r = 180;
      else if (nd == 1 && s.cy1 != NONE) r = 270;
      else hit = 1'b0;
      r = wrap360(r);
   endfunction

   task automatic model_sample(input smp_t s, input int p);
      bit hit;
      int r, sum, th;
      resolve(s, hit, r);
      if (hit) begin
         m_miss = 0;
         win.push_back(r);
         if (win.size() == N) begin
            sum = 0;
            for (int i = 1; i < N; i++) sum += norm180(win[i] - win[0]);
            th = wrap360(win[0] + floor_div(sum, N));
            exp_q.push_back('{theta: th, at_edge: p + 3});
            win.delete();
            m_lost  = 1'b0;
            m_theta = th;
         end
      end else begin
         if (m_miss < TIMEOUT) m_miss++;
         if (m_miss == TIMEOUT) begin
            m_lost = 1'b1;
            win.delete();
         end
      end
   endtask

   // One clock of stimulus; the model result becomes visible two edges after capture.
   task automatic step(input smp_t s, input bit v, input bit rst);
      int p;
      p = edge_cnt;
      reset_n  = !rst;
      in_valid = v;
      code_x1 = CODE_W'(s.cx1); code_x2 = CODE_W'(s.cx2);
      code_y1 = CODE_W'(s.cy1); code_y2 = CODE_W'(s.cy2);
      lut_x1  = LUTA_W'(s.lx1); lut_x2  = LUTA_W'(s.lx2);
      lut_y1  = LUTA_W'(s.ly1); lut_y2  = LUTA_W'(s.ly2);
      if (rst) begin
         win.delete();
         m_miss = 0; m_lost = 1'b0; m_theta = 0;
         for (int i = p - 1; i <= p; i++) begin
            if (i >= 0) begin exp_lost[i] = 1'b0; exp_theta[i] = 0; end
         end
      end else if (v) begin
         model_sample(s, p);
      end
      exp_lost[p+1]  = m_lost;
      exp_theta[p+1] = m_theta;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      smp_t z;
      z = '{default: 0};
      repeat (n) step(z, 1'b0, 1'b0);
   endtask

   function automatic smp_t mk(input int lx1, input int lx2, input int ly1, input int ly2,
                               input int cx1, input int cx2, input int cy1, input int cy2);
      smp_t s;
      s = '{cx1: cx1, cx2: cx2, cy1: cy1, cy2: cy2, lx1: lx1, lx2: lx2, ly1: ly1, ly2: ly2};
      return s;
   endfunction

   function automatic int rcode();
      return ($urandom_range(0, 1) == 1) ? NONE : int'($urandom_range(0, NONE - 1));
   endfunction

   function automatic int rlut(input bit low);
      return low ? int'($urandom_range(0, LO - 1)) : int'($urandom_range(0, (1 << LUTA_W) - 1));
   endfunction

   always @(negedge clock) begin : monitor
      emit_t e;
      if (chk_en) begin
         while (exp_q.size() > 0 && exp_q[0].at_edge < edge_cnt) begin
            check("theta_valid_missing", 0, 1);
            void'(exp_q.pop_front());
         end
         if (theta_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("theta_valid_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("theta_emit", int'(theta), e.theta);
               check("emit_edge", edge_cnt, e.at_edge);
            end
         end
         check("lost", int'(lost), int'(exp_lost[edge_cnt-2]));
         check("theta_reg", int'(theta), exp_theta[edge_cnt-2]);
      end
   end

   initial begin
      smp_t z, s;
      bit   low;
      z = '{default: 0};
      repeat (3) step(z, 1'b0, 1'b1);
      chk_en = 1'b1;

      // Quadrant rules and the wrap-around average.
      repeat (4) step(mk(45, 0, 0, 10, 0, 0, 0, 0), 1'b1, 1'b0);
      idle(4);
      repeat (4) step(mk(45, 0, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      idle(4);
      for (int i = 0; i < 4; i++)
         step(mk(3, 0, (i % 2 == 0) ? 80 : 90, 0, 0, 0, 0, 0), 1'b1, 1'b0);
      idle(4);

      // Single-code sentinels with every LUT out of range.
      repeat (4) step(mk(0, 0, 0, 0, 5, NONE, NONE, NONE), 1'b1, 1'b0);
      repeat (4) step(mk(0, 0, 0, 0, NONE, NONE, 5, NONE), 1'b1, 1'b0);
      repeat (4) step(mk(0, 0, 0, 0, NONE, 9, NONE, NONE), 1'b1, 1'b0);
      repeat (4) step(mk(0, 0, 0, 0, NONE, NONE, NONE, 2), 1'b1, 1'b0);
      idle(4);

      // Randomised traffic with gaps, misses and every channel rule.
      for (int i = 0; i < 400; i++) begin
         low = ($urandom_range(0, 2) == 0);
         s = mk(rlut(low), rlut(low), rlut(low), rlut(low), rcode(), rcode(), rcode(), rcode());
         step(s, $urandom_range(0, 4) != 0, 1'b0);
      end
      idle(4);

      // Timeout: clean window, a partial window, then TIMEOUT misses with gaps.
      repeat (4) step(mk(60, 0, 0, 5, 0, 0, 0, 0), 1'b1, 1'b0);
      repeat (2) step(mk(0, 70, 0, 5, 0, 0, 0, 0), 1'b1, 1'b0);
      for (int i = 0; i < TIMEOUT; i++) begin
         if (i % 200 == 7) idle(2);
         step(mk(0, 0, 0, 0, NONE, NONE, NONE, NONE), 1'b1, 1'b0);
      end
      repeat (20) step(mk(0, 0, 0, 0, NONE, NONE, NONE, NONE), 1'b1, 1'b0);
      idle(4);
      check("lost_after_timeout", int'(lost), 1);
      repeat (4) step(mk(0, 60, 0, 5, 0, 0, 0, 0), 1'b1, 1'b0);
      idle(4);
      check("lost_after_recovery", int'(lost), 0);
      check("theta_after_recovery", int'(theta), 120);

      // Reset in the middle of a window discards it.
      repeat (2) step(mk(45, 0, 0, 10, 0, 0, 0, 0), 1'b1, 1'b0);
      idle(3);
      step(z, 1'b0, 1'b1);
      repeat (2) step(mk(45, 0, 0, 10, 0, 0, 0, 0), 1'b1, 1'b0);
      idle(5);
      repeat (2) step(mk(45, 0, 0, 10, 0, 0, 0, 0), 1'b1, 1'b0);
      idle(6);
      check("theta_after_reset", int'(theta), 45);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/doa_tracker.md
DOA_TRACKER -- requirements
Module: doa_tracker

Interface
REQ-001 SHALL have parameter CODE_W, default 7: sensor code width; the all-ones code means "no detection".
REQ-002 SHALL have parameter LUTA_W, default 7: width of each per-channel LUT angle, in degrees.
REQ-003 SHALL have parameter ANG_W, default 9: output angle width; must be wide enough to hold 0..359.
REQ-004 SHALL have parameters LO, default 40, and HI, default 90: inclusive in-range window for a LUT angle.
REQ-005 SHALL have parameter AVG_LOG2, default 2: the averaging window is N = 2^AVG_LOG2 hits.
REQ-006 SHALL have parameter TIMEOUT, default 1024: the number of consecutive no-hit input samples before lost is declared.
REQ-007 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-009 SHALL have port in_valid, input, 1 bit: qualifies one sample per cycle; always accepted, no backpressure.
REQ-010 SHALL have ports code_x1, code_x2, code_y1, code_y2, input, CODE_W each: raw sensor codes.
REQ-011 SHALL have ports lut_x1, lut_x2, lut_y1, lut_y2, input, LUTA_W each: LUT angles, same-cycle aligned with the codes.
REQ-012 SHALL have port theta, output, ANG_W: last emitted averaged bearing, 0..359.
REQ-013 SHALL have port theta_valid, output, 1 bit: one-cycle pulse when theta updates.
REQ-014 SHALL have port lost, output, 1 bit: high while the target is considered lost.

Function
REQ-015 SHALL register all inputs in stage S1 on the cycle after in_valid; S1 holds valid only for in_valid samples.
REQ-016 SHALL resolve a raw angle r in stage S2 by priority, using r(x) = lut_x, in range meaning LO <= lut <= HI:
- x1 in range: y2>0 gives a, else 360-a
- else x2 in range: y2>0 gives 180-a, else 180+a
- else y1 in range: x1>0 gives 270+a, else 270-a
- else y2 in range: x1>0 gives 90-a, else 90+a
REQ-017 SHALL apply single-code sentinels when no channel is in range: only x1 not all-ones gives 0; only y2 gives 90; only x2 gives 180; only y1 gives 270.
REQ-018 SHALL reduce every raw result modulo 360, so that 360 becomes 0.
REQ-019 SHALL mark an S2 sample as a hit when REQ-016 or REQ-017 resolves, and as a miss otherwise.
REQ-020 SHALL implement an accumulator FSM with states IDLE and ACCUM:
- IDLE + hit: ref=r, sum=0, cnt=1, go to ACCUM
- ACCUM + hit: d=(r-ref) normalised to [-180,179]; sum+=d; cnt+=1
- misses change no FSM state
REQ-021 SHALL, on the hit that makes cnt=N:
- set theta = (ref + floor(sum/N)) mod 360, with floor taken as an arithmetic shift and the result kept in 0..359
- pulse theta_valid
- clear lost
- return to IDLE
REQ-022 SHALL size sum to hold N*180 signed without overflow.
REQ-023 SHALL hold theta between emissions and SHALL hold theta_valid low on all other cycles.
REQ-024 SHALL have a latency of 3 cycles: the N-th hit presented at cycle k gives theta/theta_valid visible at k+3.
REQ-025 SHALL count consecutive S2 misses and reset that count on any hit.
REQ-026 SHALL, when the miss count reaches TIMEOUT:
- set lost=1
- discard any partial accumulation and go to IDLE
- saturate the miss count
REQ-027 SHALL not advance the miss count on cycles without in_valid.
REQ-028 SHALL give a hit that arrives in the same cycle the timeout is reached priority: the hit is counted and lost stays 0.

Reset
REQ-029 SHALL, while reset_n=0 at a clock edge, set theta=0, theta_valid=0, lost=0, FSM=IDLE, cnt=0, sum=0, miss count=0, and S1/S2 valid=0.
REQ-030 SHALL, on reset mid-accumulation, discard the partial window and emit nothing for it; the first emission after reset requires N fresh hits.

Verification
REQ-031 SHALL be verified with defaults: 4 samples of lut_x1=45 and lut_y2=10 -> theta=45, theta_valid pulse 3 cycles after the 4th sample.
REQ-032 SHALL be verified: 4 samples of lut_x1=45 and lut_y2=0 -> theta=315.
REQ-033 SHALL be verified for wrap: lut_x1=3 with lut_y1 alternating 80, 90, 80, 90 -> raw 350, 0, 350, 0 -> theta=355.
REQ-034 SHALL be verified for sentinels with all LUTs 0:
- code_x1=5, others all-ones, 4 samples -> theta=0
- code_y1=5, others all-ones -> theta=270
REQ-035 SHALL be verified for timeout: 1024 samples with all codes all-ones -> lost=1 on the 1024th miss and theta unchanged; 4 hits afterwards -> lost=0.
REQ-036 SHALL be verified for reset mid-operation: 2 hits of 45, reset_n low 1 cycle, then 2 hits of 45 -> no theta_valid; 2 more hits -> theta_valid, theta=45.
